// File: rtl/arp_cam_learner.sv
// ARP snooper: parses the RX byte stream and writes {SPA -> SHA} into the ARP CAM.
// Optional TPA == local_ip learn filter is enabled by defining ARP_TPA_FILTER_EN.
module arp_cam_learner #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 48,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  rx_last,
    input  logic                  rx_err,
    input  logic [47:0]           local_mac,
    input  logic [31:0]           local_ip,
    output logic                  write_en,
    output logic [ADDR_WIDTH-1:0] write_key,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [CNT_WIDTH-1:0]  learn_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    typedef enum logic [1:0] {HDR, ARP, TAIL, DROP} state_e;

    state_e                state_q, state_d;
    logic [5:0]            idx_q, idx_d;
    logic                  ok_q, ok_d, ok_chk;
    logic                  bc_q, bc_d, lm_q, lm_d;
    logic [DATA_WIDTH-1:0] sha_q, sha_d;
    logic [ADDR_WIDTH-1:0] spa_q, spa_d;
    logic [7:0]            lm_byte;
    logic                  byte_ok, eof, learn, tpa_ok;
    logic                  write_en_q;
    logic [ADDR_WIDTH-1:0] write_key_q;
    logic [DATA_WIDTH-1:0] write_data_q;
    logic [CNT_WIDTH-1:0]  learn_cnt_q, learn_cnt_d, drop_cnt_q, drop_cnt_d;

`ifdef ARP_TPA_FILTER_EN
    logic [31:0] tpa_q, tpa_d;
`else
    logic unused_local_ip;
    assign unused_local_ip = ^local_ip;
`endif

    always_comb begin
        lm_byte = local_mac[47:40];
        case (idx_q[2:0])
            3'd1:    lm_byte = local_mac[39:32];
            3'd2:    lm_byte = local_mac[31:24];
            3'd3:    lm_byte = local_mac[23:16];
            3'd4:    lm_byte = local_mac[15:8];
            3'd5:    lm_byte = local_mac[7:0];
            default: lm_byte = local_mac[47:40];
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bc_d    = bc_q;
        lm_d    = lm_q;
        sha_d   = sha_q;
        spa_d   = spa_q;
`ifdef ARP_TPA_FILTER_EN
        tpa_d   = tpa_q;
`endif
        byte_ok = 1'b1;
        eof     = rx_valid && rx_last;
        if (rx_valid) begin
            if (idx_q != 6'd42) idx_d = idx_q + 6'd1;
            // dst MAC tracks broadcast and unicast candidates until the last byte
            if (idx_q <= 6'd5) begin
                bc_d = bc_q && (rx_data == 8'hFF);
                lm_d = lm_q && (rx_data == lm_byte);
                if (idx_q == 6'd5 && !bc_d && !lm_d) byte_ok = 1'b0;
            end
            case (idx_q)
                6'd12: byte_ok = (rx_data == 8'h08);
                6'd13: byte_ok = (rx_data == 8'h06);
                6'd14: byte_ok = (rx_data == 8'h00);
                6'd15: byte_ok = (rx_data == 8'h01);
                6'd16: byte_ok = (rx_data == 8'h08);
                6'd17: byte_ok = (rx_data == 8'h00);
                6'd18: byte_ok = (rx_data == 8'h06);
                6'd19: byte_ok = (rx_data == 8'h04);
                6'd20: byte_ok = (rx_data == 8'h00);
                6'd21: byte_ok = (rx_data == 8'h01) || (rx_data == 8'h02);
                default: ;
            endcase
            if (idx_q >= 6'd22 && idx_q <= 6'd27) sha_d = {sha_q[DATA_WIDTH-9:0], rx_data};
            if (idx_q >= 6'd28 && idx_q <= 6'd31) spa_d = {spa_q[ADDR_WIDTH-9:0], rx_data};
`ifdef ARP_TPA_FILTER_EN
            if (idx_q >= 6'd38 && idx_q <= 6'd41) tpa_d = {tpa_q[23:0], rx_data};
`endif
            // any earlier failure (dst included) also sends the frame to DROP
            if (state_q == HDR && idx_q == 6'd13) state_d = (ok_q && byte_ok) ? ARP : DROP;
            if (state_q == ARP && idx_q == 6'd41) state_d = TAIL;
        end
        ok_chk = ok_q && byte_ok;
        ok_d   = ok_chk;

`ifdef ARP_TPA_FILTER_EN
        tpa_ok = (tpa_d == local_ip);
`else
        tpa_ok = 1'b1;
`endif
        learn = eof && (state_q == TAIL || (state_q == ARP && idx_q == 6'd41)) &&
                ok_chk && !rx_err && (spa_d != '0) && tpa_ok;

        if (eof) begin
            state_d = HDR;
            idx_d   = 6'd0;
            ok_d    = 1'b1;
            bc_d    = 1'b1;
            lm_d    = 1'b1;
        end

        learn_cnt_d = learn_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (learn && learn_cnt_q != '1) learn_cnt_d = learn_cnt_q + 1'b1;
        if (eof && !learn && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HDR;
            idx_q        <= 6'd0;
            ok_q         <= 1'b1;
            bc_q         <= 1'b1;
            lm_q         <= 1'b1;
            sha_q        <= '0;
            spa_q        <= '0;
`ifdef ARP_TPA_FILTER_EN
            tpa_q        <= '0;
`endif
            write_en_q   <= 1'b0;
            write_key_q  <= '0;
            write_data_q <= '0;
            learn_cnt_q  <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ok_q        <= ok_d;
            bc_q        <= bc_d;
            lm_q        <= lm_d;
            sha_q       <= sha_d;
            spa_q       <= spa_d;
`ifdef ARP_TPA_FILTER_EN
            tpa_q       <= tpa_d;
`endif
            write_en_q  <= learn;
            learn_cnt_q <= learn_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            if (learn) begin
                write_key_q  <= spa_d;
                write_data_q <= sha_d;
            end
        end
    end

    assign write_en   = write_en_q;
    assign write_key  = write_key_q;
    assign write_data = write_data_q;
    assign learn_cnt  = learn_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_arp_cam_learner.sv
// Directed bench for arp_cam_learner: builds ARP frames byte by byte and checks CAM writes/counters.
module tb_arp_cam_learner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid, rx_last, rx_err;
    logic [7:0]  rx_data;
    logic [47:0] local_mac;
    logic [31:0] local_ip;
    logic        write_en;
    logic [31:0] write_key;
    logic [47:0] write_data;
    logic [15:0] learn_cnt, drop_cnt;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int wr_base;
    logic [7:0] fr [64];

    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] LMAC  = 48'h0200_0000_00AA;
    localparam logic [31:0] LIP   = 32'h0A00_0001;

    arp_cam_learner dut (
        .clk(clk), .rst_n(rst_n),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last), .rx_err(rx_err),
        .local_mac(local_mac), .local_ip(local_ip),
        .write_en(write_en), .write_key(write_key), .write_data(write_data),
        .learn_cnt(learn_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (write_en === 1'b1) wr_cnt <= wr_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build(input logic [47:0] dst, input logic [15:0] etype, input logic [15:0] oper,
                         input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa);
        for (int i = 0; i < 64; i++) fr[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            fr[i]      = 8'(dst >> (40 - 8*i));
            fr[6 + i]  = 8'(48'h0200_0000_0099 >> (40 - 8*i));
            fr[22 + i] = 8'(sha >> (40 - 8*i));
        end
        fr[12] = etype[15:8]; fr[13] = etype[7:0];
        fr[14] = 8'h00; fr[15] = 8'h01; fr[16] = 8'h08; fr[17] = 8'h00;
        fr[18] = 8'h06; fr[19] = 8'h04;
        fr[20] = oper[15:8]; fr[21] = oper[7:0];
        for (int i = 0; i < 4; i++) begin
            fr[28 + i] = 8'(spa >> (24 - 8*i));
            fr[38 + i] = 8'(tpa >> (24 - 8*i));
        end
    endtask

    // Drives fr[from..to]; rx_last on 'to' when do_last. Optional 3-cycle gaps before bytes 5, 25, 40.
    task automatic send(input int from, input int to, input bit do_last, input bit err, input bit gaps);
        for (int i = from; i <= to; i++) begin
            if (gaps && (i == 5 || i == 25 || i == 40)) begin
                repeat (3) begin
                    @(negedge clk);
                    rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
                end
            end
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = fr[i];
            rx_last  = do_last && (i == to);
            rx_err   = err && (i == to);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
        end
    endtask

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
        local_mac = LMAC; local_ip = LIP;
        repeat (2) @(negedge clk);
        chk("rst_write_en", 64'(write_en), 64'd0);
        chk("rst_write_key", 64'(write_key), 64'd0);
        chk("rst_write_data", 64'(write_data), 64'd0);
        chk("rst_learn_cnt", 64'(learn_cnt), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        rst_n = 1'b1;
        idle(1);

        // padded broadcast request
        build(BCAST, 16'h0806, 16'd1, 48'h0200_0000_0001, 32'hC0A8_010A, LIP);
        wr_base = wr_cnt;
        send(0, 59, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("req_write_en", 64'(write_en), 64'd1);
        chk("req_write_key", 64'(write_key), 64'hC0A8_010A);
        chk("req_write_data", 64'(write_data), 64'h0200_0000_0001);
        chk("req_learn_cnt", 64'(learn_cnt), 64'd1);
        idle(2);
        chk("req_write_en_clear", 64'(write_en), 64'd0);
        chk("req_one_pulse", 64'(wr_cnt - wr_base), 64'd1);

        // wrong ethertype, then rx_err
        build(BCAST, 16'h0800, 16'd1, 48'h0200_0000_0001, 32'hC0A8_010A, LIP);
        wr_base = wr_cnt;
        send(0, 59, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("etype_drop_cnt", 64'(drop_cnt), 64'd1);
        build(BCAST, 16'h0806, 16'd1, 48'h0200_0000_0001, 32'hC0A8_010A, LIP);
        send(0, 59, 1'b1, 1'b1, 1'b0);
        idle(3);
        chk("err_drop_cnt", 64'(drop_cnt), 64'd2);
        chk("etype_err_no_write", 64'(wr_cnt - wr_base), 64'd0);
        chk("etype_err_learn_cnt", 64'(learn_cnt), 64'd1);

        // runt followed back-to-back by unicast reply ending exactly at byte 41
        wr_base = wr_cnt;
        send(0, 30, 1'b1, 1'b0, 1'b0);
        build(LMAC, 16'h0806, 16'd2, 48'h0200_0000_0002, 32'hC0A8_0114, LIP);
        send(0, 41, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("b2b_write_en", 64'(write_en), 64'd1);
        chk("b2b_write_key", 64'(write_key), 64'hC0A8_0114);
        chk("b2b_write_data", 64'(write_data), 64'h0200_0000_0002);
        idle(2);
        chk("b2b_one_pulse", 64'(wr_cnt - wr_base), 64'd1);
        chk("b2b_drop_cnt", 64'(drop_cnt), 64'd3);
        chk("b2b_learn_cnt", 64'(learn_cnt), 64'd2);

        // same request with valid gaps
        build(BCAST, 16'h0806, 16'd1, 48'h0200_0000_0001, 32'hC0A8_010A, LIP);
        wr_base = wr_cnt;
        send(0, 59, 1'b1, 1'b0, 1'b1);
        idle(1);
        chk("gap_write_en", 64'(write_en), 64'd1);
        chk("gap_write_key", 64'(write_key), 64'hC0A8_010A);
        chk("gap_write_data", 64'(write_data), 64'h0200_0000_0001);
        idle(2);
        chk("gap_one_pulse", 64'(wr_cnt - wr_base), 64'd1);
        chk("gap_learn_cnt", 64'(learn_cnt), 64'd3);

        // reset after byte 20, remainder of the frame must be dropped
        wr_base = wr_cnt;
        send(0, 20, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rx_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(21, 59, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("rst_mid_no_write", 64'(wr_cnt - wr_base), 64'd0);
        chk("rst_mid_drop_cnt", 64'(drop_cnt), 64'd1);
        chk("rst_mid_learn_cnt", 64'(learn_cnt), 64'd0);
        send(0, 59, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("rst_fresh_one_pulse", 64'(wr_cnt - wr_base), 64'd1);
        chk("rst_fresh_learn_cnt", 64'(learn_cnt), 64'd1);

        // ARP probe (SPA 0.0.0.0) is not learned
        build(BCAST, 16'h0806, 16'd1, 48'h0200_0000_0003, 32'h0000_0000, LIP);
        wr_base = wr_cnt;
        send(0, 45, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("probe_no_write", 64'(wr_cnt - wr_base), 64'd0);
        chk("probe_drop_cnt", 64'(drop_cnt), 64'd2);
        chk("probe_key_held", 64'(write_key), 64'hC0A8_010A);

        // learn counter saturation
        force dut.learn_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.learn_cnt_q;
        build(LMAC, 16'h0806, 16'd2, 48'h0200_0000_0004, 32'hC0A8_0105, LIP);
        wr_base = wr_cnt;
        send(0, 59, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("sat_one_pulse", 64'(wr_cnt - wr_base), 64'd1);
        chk("sat_write_key", 64'(write_key), 64'hC0A8_0105);
        chk("sat_learn_cnt", 64'(learn_cnt), 64'hFFFF);

`ifdef ARP_TPA_FILTER_EN
        build(BCAST, 16'h0806, 16'd1, 48'h0200_0000_0005, 32'hC0A8_0106, 32'h0A00_0002);
        wr_base = wr_cnt;
        send(0, 59, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("tpa_miss_no_write", 64'(wr_cnt - wr_base), 64'd0);
        chk("tpa_miss_drop_cnt", 64'(drop_cnt), 64'd3);
        build(BCAST, 16'h0806, 16'd1, 48'h0200_0000_0005, 32'hC0A8_0106, LIP);
        send(0, 59, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("tpa_hit_one_pulse", 64'(wr_cnt - wr_base), 64'd1);
        chk("tpa_hit_write_key", 64'(write_key), 64'hC0A8_0106);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arp_cam_learner.md
Name: arp_cam_learner

Overview:
Write-side companion to the Ethernet ARP CAM: sniffs the RX MAC byte stream and parses Ethernet/ARP frames. On each valid ARP request or reply, it issues a single-cycle write of {SPA -> SHA} into the CAM write port. Sits between the RX MAC byte interface and the CAM inside the Ethernet MMIO peripheral. Pure sink: never backpressures.

Parameters:
ADDR_WIDTH, 32, CAM key width; must be 32 (IPv4 SPA).
DATA_WIDTH, 48, CAM data width; must be 48 (MAC SHA).
CNT_WIDTH, 16, width of the learn and drop statistics counters.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_valid  in  1  byte valid; every valid cycle is accepted
rx_data  in  8  frame byte: dst MAC first, network byte order, no FCS
rx_last  in  1  final byte of frame, qualified by rx_valid
rx_err  in  1  frame error, sampled with rx_valid && rx_last
local_mac  in  48  own MAC, for dst filter
local_ip  in  32  own IPv4, for TPA filter (optional feature)
write_en  out  1  CAM write strobe, 1-cycle pulse
write_key  out  ADDR_WIDTH  learned SPA
write_data  out  DATA_WIDTH  learned SHA
learn_cnt  out  CNT_WIDTH  frames learned, saturating
drop_cnt  out  CNT_WIDTH  frames completed without learning, saturating

Behaviour:
- Clock is clk. Reset rst_n is asynchronous and active-low.
- Reset values: write_en=0, write_key=0, write_data=0, learn_cnt=0, drop_cnt=0. State=HDR, byte index=0, ok flag=1.
- Byte index: 6-bit counter, incremented on each accepted byte and saturating at 42. It is cleared after rx_last.
- Check the fields by byte index:
  - bytes 0-5 dst MAC: must equal FF:FF:FF:FF:FF:FF or local_mac.
  - bytes 12-13 ethertype: must be 0x0806.
  - bytes 14-15 HTYPE: must be 0x0001.
  - bytes 16-17 PTYPE: must be 0x0800.
  - byte 18 HLEN: must be 6.
  - byte 19 PLEN: must be 4.
  - bytes 20-21 OPER: must be 1 or 2.
  - bytes 22-27: shift into the SHA register.
  - bytes 28-31: shift into the SPA register.
  - bytes 38-41 TPA: shifted into the TPA register.
- Any mismatch clears the ok flag. Bytes 42 and later (padding) are ignored.
- States:
  - HDR: bytes 0-13. If ethertype fails at byte 13, go to DROP.
  - ARP: bytes 14-41. Go to TAIL after byte 41.
  - TAIL: wait for rx_last.
  - DROP: discard until rx_last.
- End of frame is the cycle with rx_valid && rx_last.
- Learn condition: state is TAIL, or state is ARP with byte index 41 when rx_last arrives. In addition, ok=1, rx_err=0, and SPA != 0.0.0.0 (probes are not learned).
- On learn, the next cycle drives write_en=1 with write_key=SPA and write_data=SHA, and learn_cnt increments.
- Otherwise drop_cnt increments on the next cycle. This covers runts (rx_last before byte 41), failed checks and rx_err.
- write_key and write_data hold their values until the next learn.
- After end of frame: state=HDR, index=0, ok=1. A new frame may start on the very next cycle (back-to-back). The write_en pulse overlaps byte 0 of the next frame.
- Counters saturate at all-ones and never wrap.
- rx_valid low: no state change. Gaps are allowed anywhere in a frame.
- Reset mid-frame: the block returns to HDR immediately. The remainder of the interrupted frame is parsed as a new frame and dropped by the checks; upstream is responsible for frame alignment after reset. No partial write is ever issued.
- No deduplication: a repeated SPA is written again.

Optional Feature:
- Macro: ARP_TPA_FILTER_EN.
- Defined: the learn condition additionally requires TPA == local_ip. Mismatching frames count in drop_cnt.
- Undefined: TPA is ignored and local_ip is unused. All valid ARP frames are learned (gratuitous/promiscuous learning).

Test Plan:
- Broadcast ARP request, SHA=02:00:00:00:00:01, SPA=192.168.1.10, rx_last at byte 59 (padded) -> one cycle later write_en=1, write_key=0xC0A8010A, write_data=0x020000000001, learn_cnt=1.
- Same frame with ethertype 0x0800 -> no write_en, drop_cnt=1. A frame with rx_err=1 on the last byte -> drop_cnt=2.
- Runt: ARP frame with rx_last at byte 30 -> no write. A following back-to-back valid reply (OPER=2, dst=local_mac) -> exactly one write_en.
- rx_valid deasserted for 3 cycles at bytes 5, 25 and 40 -> identical write to the gap-free case.
- Assert rst_n low at byte 20, release, then continue the stream -> no write_en. After a fresh valid frame -> one write, learn_cnt=1.
- With ARP_TPA_FILTER_EN, local_ip=10.0.0.1: TPA=10.0.0.2 -> drop. TPA=10.0.0.1 -> write. Force learn_cnt to 0xFFFF, then learn again -> stays 0xFFFF.
